calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_calc_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Operand/opcode entry sequencer for an external ALU: debounced Enter/Clear buttons
// drive a five-state FSM that registers operands, waits out the ALU latency and captures the result.
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] Switchs,
  input  logic        Enter,
  input  logic        Clear,
  output logic [7:0]  AluA,
  output logic [7:0]  AluB,
  output logic [3:0]  AluOp,
  input  logic [7:0]  AluResult,
  input  logic        AluZero,
  input  logic        AluCarry,
  input  logic        AluOverflow,
  output logic [7:0]  Result,
  output logic [2:0]  Flags,
  output logic        ShowA,
  output logic        ShowB,
  output logic        ShowResult,
  output logic [5:0]  Leds,
  output logic        Busy
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    HAVE_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

  // Button conditioning, bit 0 = Enter, bit 1 = Clear
  logic [1:0] btn_raw, sync_p0, sync_p1, deb_lvl, press;
  logic [7:0] deb_cnt [2];
  logic       enter_press, clear_press;

  assign btn_raw     = {Clear, Enter};
  assign enter_press = press[0];
  assign clear_press = press[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      deb_lvl    <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_p1[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          // level accepted; only the rising acceptance counts as a press
          deb_cnt[i] <= '0;
          deb_lvl[i] <= sync_p1[i];
          press[i]   <= sync_p1[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  state_t     state, state_nxt;
  logic [3:0] lat_cnt, lat_cnt_nxt;
  logic [7:0] alu_a_nxt, alu_b_nxt, result_nxt;
  logic [3:0] alu_op_nxt;
  logic [2:0] flags_nxt;
  logic       show_a_nxt, show_b_nxt, show_result_nxt, busy_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      AluA       <= '0;
      AluB       <= '0;
      AluOp      <= '0;
      Result     <= '0;
      Flags      <= '0;
      ShowA      <= 1'b0;
      ShowB      <= 1'b0;
      ShowResult <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      AluA       <= alu_a_nxt;
      AluB       <= alu_b_nxt;
      AluOp      <= alu_op_nxt;
      Result     <= result_nxt;
      Flags      <= flags_nxt;
      ShowA      <= show_a_nxt;
      ShowB      <= show_b_nxt;
      ShowResult <= show_result_nxt;
      Busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear_press) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (enter_press) state_nxt = HAVE_A;
        HAVE_A:  if (enter_press) state_nxt = HAVE_B;
        HAVE_B:  if (enter_press) state_nxt = EXEC;
        EXEC:    if (lat_cnt == 4'd0) state_nxt = DONE;
        DONE:    if (enter_press) state_nxt = HAVE_A;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    lat_cnt_nxt     = lat_cnt;
    alu_a_nxt       = AluA;
    alu_b_nxt       = AluB;
    alu_op_nxt      = AluOp;
    result_nxt      = Result;
    flags_nxt       = Flags;
    show_a_nxt      = ShowA;
    show_b_nxt      = ShowB;
    show_result_nxt = ShowResult;
    busy_nxt        = Busy;
    case (state)
      HAVE_A:  Leds = 6'b000011;
      HAVE_B:  Leds = 6'b000111;
      EXEC:    Leds = 6'b001111;
      DONE:    Leds = {Flags[2], Flags[1], 4'b1111};
      default: Leds = 6'b000001;
    endcase
    if (clear_press || !(state inside {IDLE, HAVE_A, HAVE_B, EXEC, DONE})) begin
      lat_cnt_nxt     = '0;
      alu_a_nxt       = '0;
      alu_b_nxt       = '0;
      alu_op_nxt      = '0;
      result_nxt      = '0;
      flags_nxt       = '0;
      show_a_nxt      = 1'b0;
      show_b_nxt      = 1'b0;
      show_result_nxt = 1'b0;
      busy_nxt        = 1'b0;
    end else begin
      case (state)
        IDLE: if (enter_press) begin
          alu_a_nxt  = Switchs[7:0];
          show_a_nxt = 1'b1;
        end
        HAVE_A: if (enter_press) begin
          alu_b_nxt  = Switchs[7:0];
          show_b_nxt = 1'b1;
        end
        HAVE_B: if (enter_press) begin
          alu_op_nxt  = Switchs[11:8];
          lat_cnt_nxt = LAT_INIT;
          busy_nxt    = 1'b1;
        end
        EXEC: begin
          // capture one edge after the count hits zero, so the ALU has had ALU_LATENCY edges
          if (lat_cnt == 4'd0) begin
            result_nxt      = AluResult;
            flags_nxt       = {AluOverflow, AluCarry, AluZero};
            show_result_nxt = 1'b1;
            busy_nxt        = 1'b0;
          end else begin
            lat_cnt_nxt = lat_cnt - 4'd1;
          end
        end
        DONE: if (enter_press) begin
          alu_a_nxt       = Switchs[7:0];
          show_b_nxt      = 1'b0;
          show_result_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer with a registered ALU model
// and an operation-level reference of the calculator's visible state.
module tb_calc_sequencer;
  localparam int DB     = 3;
  localparam int LAT    = 15;
  localparam int SETTLE = DB + 6;
  localparam int S_IDLE = 0, S_A = 1, S_B = 2, S_DONE = 4;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [11:0] Switchs = '0;
  logic        Enter   = 1'b0;
  logic        Clear   = 1'b0;
  logic [7:0]  AluA, AluB, AluResult, Result;
  logic [3:0]  AluOp;
  logic        AluZero, AluCarry, AluOverflow;
  logic [2:0]  Flags;
  logic        ShowA, ShowB, ShowResult, Busy;
  logic [5:0]  Leds;

  int total = 0;
  int bad   = 0;

  int         m_state;
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_op;
  logic [2:0] m_flags;
  logic       m_sa, m_sb, m_sr;

  logic [10:0] alu_pipe [LAT];

  always #5 clock = ~clock;

  calc_sequencer #(.DEBOUNCE_CYCLES(DB), .ALU_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .Switchs(Switchs), .Enter(Enter), .Clear(Clear),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluResult(AluResult),
    .AluZero(AluZero), .AluCarry(AluCarry), .AluOverflow(AluOverflow),
    .Result(Result), .Flags(Flags), .ShowA(ShowA), .ShowB(ShowB), .ShowResult(ShowResult),
    .Leds(Leds), .Busy(Busy)
  );

  // {overflow, carry, zero, result}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] w;
    logic       v;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      4'd2: begin w = {1'b0, a & b}; v = 1'b0; end
      default: begin w = {1'b0, a | b}; v = 1'b0; end
    endcase
    return {v, w[8], (w[7:0] == 8'd0), w[7:0]};
  endfunction

  always @(posedge clock) begin
    alu_pipe[0] <= alu_f(AluA, AluB, AluOp);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {AluOverflow, AluCarry, AluZero, AluResult} = alu_pipe[LAT-1];

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] m_leds();
    case (m_state)
      S_A:     return 6'b000011;
      S_B:     return 6'b000111;
      S_DONE:  return {m_flags[2], m_flags[1], 4'b1111};
      default: return 6'b000001;
    endcase
  endfunction

  task automatic m_reset();
    m_state = S_IDLE;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0;
    m_sa = 1'b0; m_sb = 1'b0; m_sr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"}, AluA, m_a);
    chk({tag, ".b"}, AluB, m_b);
    chk({tag, ".op"}, AluOp, m_op);
    chk({tag, ".res"}, Result, m_res);
    chk({tag, ".flags"}, Flags, m_flags);
    chk({tag, ".show"}, {ShowA, ShowB, ShowResult}, {m_sa, m_sb, m_sr});
    chk({tag, ".leds"}, Leds, m_leds());
    chk({tag, ".busy"}, Busy, 0);
  endtask

  // Enter press outside HAVE_B; the model advances one step
  task automatic press(input logic [11:0] sw, input int hold);
    Switchs = sw;
    Enter = 1'b1;
    cycles(hold);
    Enter = 1'b0;
    cycles(SETTLE);
    case (m_state)
      S_IDLE: begin m_a = sw[7:0]; m_sa = 1'b1; m_state = S_A; end
      S_A:    begin m_b = sw[7:0]; m_sb = 1'b1; m_state = S_B; end
      S_DONE: begin m_a = sw[7:0]; m_sb = 1'b0; m_sr = 1'b0; m_state = S_A; end
      default: ;
    endcase
  endtask

  task automatic clear_press();
    Clear = 1'b1;
    cycles(SETTLE);
    Clear = 1'b0;
    cycles(SETTLE);
    m_reset();
  endtask

  // mode 0: plain; 1: extra press in EXEC; 2: extra press then reset; 3: Clear aborts EXEC
  task automatic run_exec(input logic [11:0] sw, input int mode);
    logic [10:0] want;
    logic [7:0]  old_res;
    int          k;
    old_res = m_res;
    want    = alu_f(m_a, m_b, sw[11:8]);
    Switchs = sw;
    Enter   = 1'b1;
    k = 0;
    while (!Busy && k < 40) begin
      cycles(1);
      k++;
    end
    chk("exec.enter", Busy, 1);
    chk("exec.op", AluOp, sw[11:8]);
    chk("exec.leds", Leds, 6'b001111);
    for (int c = 1; c <= LAT + 1; c++) begin
      if (mode == 1 || mode == 2) Enter = (c >= 6);
      if (mode == 3) Clear = (c >= 2);
      cycles(1);
      if (c <= LAT && mode != 3) begin
        chk("exec.hold", Result, old_res);
        chk("exec.busy", Busy, 1);
      end
      if (mode == 2 && c == 13) begin
        chk("exec.ignored_a", AluA, m_a);
        chk("exec.ignored_leds", Leds, 6'b001111);
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all("rst_async");
        cycles(2);
        reset_n = 1'b1;
        cycles(DB + 1);
        check_all("rst_hold");
        cycles(10);
        Enter = 1'b0;
        m_a = sw[7:0]; m_sa = 1'b1; m_state = S_A;
        cycles(SETTLE);
        check_all("rst_press");
        return;
      end
      if (mode == 3 && c == 12) begin
        Clear = 1'b0;
        cycles(SETTLE);
        Enter = 1'b0;
        cycles(SETTLE);
        m_reset();
        check_all("exec_clear");
        return;
      end
      if (c == LAT + 1) begin
        chk("exec.result", Result, want[7:0]);
        chk("exec.flags", Flags, want[10:8]);
        chk("exec.show", ShowResult, 1);
        chk("exec.busy_end", Busy, 0);
      end
    end
    Enter = 1'b0;
    cycles(SETTLE);
    m_op = sw[11:8]; m_res = want[7:0]; m_flags = want[10:8];
    m_sr = 1'b1; m_state = S_DONE;
    check_all("exec.done");
  endtask

  task automatic clear_enter_same();
    logic saw_busy;
    saw_busy = 1'b0;
    Switchs = 12'h1ff;
    Clear = 1'b1;
    Enter = 1'b1;
    for (int c = 0; c < 2 * SETTLE; c++) begin
      cycles(1);
      if (Busy) saw_busy = 1'b1;
      if (c == SETTLE) begin
        Clear = 1'b0;
        Enter = 1'b0;
      end
    end
    chk("ce.no_exec", saw_busy, 0);
    m_reset();
    check_all("ce");
  endtask

  initial begin
    logic [11:0] sw;
    int          r;
    m_reset();
    #2 reset_n = 1'b0;
    #1;
    check_all("reset");
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
    check_all("post_reset");

    press(12'h019, SETTLE);
    check_all("a25");
    press(12'h011, SETTLE);
    check_all("b17");
    run_exec(12'h000, 0);
    chk("r42", Result, 8'd42);
    chk("f42", Flags, 3'b000);
    chk("leds42", Leds, 6'b001111);

    press(12'h007, SETTLE);
    check_all("done_a");
    chk("a7", AluA, 8'd7);
    chk("b_kept", AluB, 8'd17);
    chk("res_kept", Result, 8'd42);

    clear_press();
    check_all("clr");
    press(12'h0C8, SETTLE);
    press(12'h064, SETTLE);
    run_exec(12'h000, 1);
    chk("r44", Result, 8'd44);
    chk("carry", Flags[1], 1);
    chk("led4", Leds[4], 1);

    press(12'h005, SETTLE);
    press(12'h005, SETTLE);
    run_exec(12'h100, 0);
    chk("r0", Result, 8'd0);
    chk("zero", Flags[0], 1);

    Switchs = 12'h0AA;
    Enter = 1'b1;
    cycles(DB - 1);
    Enter = 1'b0;
    cycles(SETTLE);
    check_all("glitch");
    press(12'h033, 50);
    check_all("hold50");

    press(12'h044, SETTLE);
    clear_enter_same();

    press(12'h012, SETTLE);
    press(12'h034, SETTLE);
    run_exec(12'h000, 3);

    press(12'h056, SETTLE);
    press(12'h078, SETTLE);
    run_exec(12'h000, 2);

    repeat (30) begin
      r  = $urandom_range(0, 5);
      sw = 12'($urandom);
      if (r == 0) begin
        clear_press();
        check_all("rnd_clear");
      end else if (m_state == S_B) begin
        run_exec({4'($urandom_range(0, 3)), sw[7:0]}, $urandom_range(0, 1));
      end else begin
        press(sw, $urandom_range(DB + 3, 20));
        check_all("rnd_enter");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
